mem_ctrl_rr_coalesce: RTL and testbench



---
 rtl/mem_ctrl_rr_coalesce.sv | 154 +++++++++++++++
 tb/tb_mem_ctrl_rr_coalesce.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_rr_coalesce.sv
// ============================================================================
// mem_ctrl_rr_coalesce : round-robin shared data memory with request coalescing
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_ctrl_rr_coalesce #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 256,
  parameter int COALESCE  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CORES-1:0]          req_i,
  input  logic [NUM_CORES-1:0]          we_i,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr_i,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata_i,
  output logic [NUM_CORES-1:0]          ack_o,
  output logic [NUM_CORES*DATA_W-1:0]   rdata_o,
  output logic                          busy_o
);

  localparam int PTR_W = $clog2(NUM_CORES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]              leader_q, leader_d;
  logic [NUM_CORES-1:0]          grp_q, grp_d;
  logic [IDX_W-1:0]              grp_addr_q, grp_addr_d;
  logic                          grp_we_q, grp_we_d;
  logic [NUM_CORES*DATA_W-1:0]   wdata_q, wdata_d;
  logic [NUM_CORES*DATA_W-1:0]   rdata_q, rdata_d;

  logic [PTR_W-1:0]              w_leader;
  logic [NUM_CORES-1:0]          w_grp;
  logic [IDX_W-1:0]              w_idx [NUM_CORES];
  logic [NUM_CORES*DATA_W-1:0]   w_ram_rd;

  // Word index per core; address bits above the RAM depth alias.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_idx
    assign w_idx[gi] = addr_i[gi*ADDR_W +: IDX_W];
  end

  // Last pending core found when scanning backwards is the first one from rr_ptr.
  always_comb begin
    int idx;
    w_leader = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (req_i[PTR_W'(idx)]) w_leader = PTR_W'(idx);
    end
  end

  always_comb begin
    w_grp = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (COALESCE != 0) begin
        w_grp[i] = req_i[i] && (we_i[i] == we_i[w_leader]) && (w_idx[i] == w_idx[w_leader]);
      end else begin
        w_grp[i] = (PTR_W'(i) == w_leader) && req_i[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    leader_d   = leader_q;
    grp_d      = grp_q;
    grp_addr_d = grp_addr_q;
    grp_we_d   = grp_we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          leader_d   = w_leader;
          grp_d      = w_grp;
          grp_addr_d = w_idx[w_leader];
          grp_we_d   = we_i[w_leader];
          wdata_d    = wdata_i;
          state_d    = ACCESS;
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        if (!grp_we_q) begin
          for (int i = 0; i < NUM_CORES; i++) begin
            if (grp_q[i]) rdata_d[i*DATA_W +: DATA_W] = w_ram_rd[i*DATA_W +: DATA_W];
          end
        end
        rr_ptr_d = (leader_q == PTR_W'(NUM_CORES - 1)) ? '0 : leader_q + PTR_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      leader_q   <= '0;
      grp_q      <= '0;
      grp_addr_q <= '0;
      grp_we_q   <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      leader_q   <= leader_d;
      grp_q      <= grp_d;
      grp_addr_q <= grp_addr_d;
      grp_we_q   <= grp_we_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // One RAM per lane gives the per-lane write enable; a write is blocked by reset.
  for (genvar gl = 0; gl < NUM_CORES; gl++) begin : g_lane
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic              w_wr_en;

    assign w_wr_en = (state_q == ACCESS) && grp_we_q && grp_q[gl] && !reset;

    always_ff @(posedge clk) begin
      if (w_wr_en) mem[grp_addr_q] <= wdata_q[gl*DATA_W +: DATA_W];
      if (state_q == ACCESS) rd_q <= mem[grp_addr_q];
    end

    assign w_ram_rd[gl*DATA_W +: DATA_W] = rd_q;
  end

  // Load data is forwarded during the ack cycle and held afterwards.
  assign rdata_o = rdata_d;
  assign ack_o   = (state_q == RESP) ? grp_q : '0;
  assign busy_o  = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl_rr_coalesce.sv
// ============================================================================
// tb_mem_ctrl_rr_coalesce : directed vector bench for mem_ctrl_rr_coalesce
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_ctrl_rr_coalesce;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, we, ack;
  logic [63:0] addr, wdata, rdata;
  logic        busy;
  logic [3:0]  req0, we0, ack0;
  logic [63:0] addr0, wdata0, rdata0;
  logic        busy0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_ctrl_rr_coalesce #(
    .NUM_CORES(4), .DATA_W(16), .ADDR_W(16), .DEPTH(256), .COALESCE(1)
  ) dut (
    .clk(clk), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .busy_o(busy)
  );

  mem_ctrl_rr_coalesce #(
    .NUM_CORES(4), .DATA_W(16), .ADDR_W(16), .DEPTH(256), .COALESCE(0)
  ) dut0 (
    .clk(clk), .reset(reset), .req_i(req0), .we_i(we0), .addr_i(addr0),
    .wdata_i(wdata0), .ack_o(ack0), .rdata_o(rdata0), .busy_o(busy0)
  );

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [3:0]  exp_ack;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One grouped transaction: ack two edges after issue, back to idle one edge later.
  task automatic apply_vec(input vec_t v, input string nm);
    req = v.req; we = v.we; addr = v.addr; wdata = v.wd;
    tick();
    chk({nm, " ack_access"}, 64'(ack), 64'h0);
    chk({nm, " busy_access"}, 64'(busy), 64'h1);
    tick();
    chk({nm, " ack_resp"}, 64'(ack), 64'(v.exp_ack));
    chk({nm, " rdata"}, rdata, v.exp_rd);
    req = 4'h0;
    tick();
    chk({nm, " ack_idle"}, 64'(ack), 64'h0);
    chk({nm, " busy_idle"}, 64'(busy), 64'h0);
  endtask

  initial begin
    vec_t v;
    logic [3:0] exp_a;

    //             req    we     addr {c3,c2,c1,c0}                        wdata {c3,c2,c1,c0}                                  ack    rdata {c3,c2,c1,c0}
    vecs[0] = '{4'hF, 4'hF, {4{16'h0005}},                              64'h0,                                               4'hF, 64'h0};
    vecs[1] = '{4'h1, 4'h1, {4{16'h0005}},                              {16'h0, 16'h0, 16'h0, 16'hBEEF},                      4'h1, 64'h0};
    vecs[2] = '{4'hF, 4'h0, {4{16'h0005}},                              64'h0,                                               4'hF, {16'h0, 16'h0, 16'h0, 16'hBEEF}};
    vecs[3] = '{4'hF, 4'hF, {4{16'h0009}},                              {16'h4444, 16'h3333, 16'h2222, 16'h1111},             4'hF, {16'h0, 16'h0, 16'h0, 16'hBEEF}};
    vecs[4] = '{4'hF, 4'h0, {4{16'h0009}},                              64'h0,                                               4'hF, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    vecs[5] = '{4'h6, 4'h6, {4{16'h0009}},                              {16'h0, 16'h6666, 16'h5555, 16'h0},                   4'h6, {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    vecs[6] = '{4'hF, 4'h0, {4{16'h0009}},                              64'h0,                                               4'hF, {16'h4444, 16'h6666, 16'h5555, 16'h1111}};
    vecs[7] = '{4'h8, 4'h8, {16'h0109, 16'h0, 16'h0, 16'h0},            {16'h7777, 16'h0, 16'h0, 16'h0},                      4'h8, {16'h4444, 16'h6666, 16'h5555, 16'h1111}};
    vecs[8] = '{4'h9, 4'h0, {16'h0009, 16'h0, 16'h0, 16'h0009},         64'h0,                                               4'h9, {16'h7777, 16'h6666, 16'h5555, 16'h1111}};
    vecs[9] = '{4'h2, 4'h0, {16'h0, 16'h0, 16'h0305, 16'h0},            64'h0,                                               4'h2, {16'h7777, 16'h6666, 16'h0000, 16'h1111}};

    reset = 1'b1;
    req = '0; we = '0; addr = '0; wdata = '0;
    req0 = '0; we0 = '0; addr0 = '0; wdata0 = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("reset ack", 64'(ack), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset rdata", rdata, 64'h0);
    chk("reset ack0", 64'(ack0), 64'h0);
    tick();
    chk("idle busy", 64'(busy), 64'h0);

    for (int i = 0; i < 10; i++) begin
      apply_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset during the ACCESS cycle of a store must suppress the write and ack.
    v = '{4'h1, 4'h1, {4{16'h0002}}, {48'h0, 16'h1234}, 4'h1, {16'h7777, 16'h6666, 16'h0000, 16'h1111}};
    apply_vec(v, "pre_store");
    req = 4'h1; we = 4'h1; addr = {4{16'h0002}}; wdata = {48'h0, 16'hAAAA};
    tick();
    chk("rst_mid busy", 64'(busy), 64'h1);
    reset = 1'b1;
    tick();
    chk("rst_mid ack", 64'(ack), 64'h0);
    chk("rst_mid busy_after", 64'(busy), 64'h0);
    chk("rst_mid rdata", rdata, 64'h0);
    reset = 1'b0; req = 4'h0;
    tick();
    chk("rst_mid ack_idle", 64'(ack), 64'h0);
    v = '{4'h1, 4'h0, {4{16'h0002}}, 64'h0, 4'h1, {48'h0, 16'h1234}};
    apply_vec(v, "rst_mid load");
    v = '{4'h1, 4'h1, {48'h0, 16'h0102}, {48'h0, 16'h5A5A}, 4'h1, {48'h0, 16'h1234}};
    apply_vec(v, "wrap store");
    v = '{4'h1, 4'h0, {48'h0, 16'h0002}, 64'h0, 4'h1, {48'h0, 16'h5A5A}};
    apply_vec(v, "wrap load");

    // Round robin: cores 1 and 2 conflict with rr_ptr cleared by reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'h6; we = 4'h0; addr = {16'h0, 16'h0007, 16'h0003, 16'h0};
    tick();
    chk("rr ack t1", 64'(ack), 64'h0);
    tick();
    chk("rr ack core1", 64'(ack), 64'h2);
    req = 4'h4;
    for (int c = 3; c <= 5; c++) begin
      tick();
      chk($sformatf("rr ack t%0d", c), 64'(ack), (c == 5) ? 64'h4 : 64'h0);
    end
    req = 4'h0;
    tick();
    // rr_ptr is now 3: core3 leads, then wraps to core0.
    req = 4'hF; we = 4'h0; addr = {16'd13, 16'd12, 16'd11, 16'd10};
    tick();
    tick();
    chk("rr wrap core3", 64'(ack), 64'h8);
    req = 4'h7;
    tick();
    tick();
    tick();
    chk("rr wrap core0", 64'(ack), 64'h1);
    req = 4'h0;
    tick();

    // Mixed op at one address: store leads, the load follows a round later.
    v = '{4'h2, 4'h2, {4{16'h0004}}, {16'h0, 16'h0, 16'h0B0B, 16'h0}, 4'h2, 64'h0};
    apply_vec(v, "mixed prestore");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'h3; we = 4'h1; addr = {4{16'h0004}}; wdata = {48'h0, 16'h4444};
    tick();
    tick();
    chk("mixed ack store", 64'(ack), 64'h1);
    req = 4'h2;
    tick();
    chk("mixed ack gap1", 64'(ack), 64'h0);
    tick();
    chk("mixed ack gap2", 64'(ack), 64'h0);
    tick();
    chk("mixed ack load", 64'(ack), 64'h2);
    chk("mixed rdata", rdata, {16'h0, 16'h0, 16'h0B0B, 16'h0});
    req = 4'h0;
    tick();

    // Leader-only build: four stores to one word are serialised 0,1,2,3.
    req0 = 4'hF; we0 = 4'hF; addr0 = {4{16'h0009}};
    wdata0 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp_a = (c % 3 == 2) ? (4'h1 << ((c - 2) / 3)) : 4'h0;
      chk($sformatf("serial ack c%0d", c), 64'(ack0), 64'(exp_a));
      req0 = req0 & ~ack0;
    end
    req0 = 4'h4; we0 = 4'h0;
    tick();
    tick();
    chk("serial load ack", 64'(ack0), 64'h4);
    chk("serial load rdata", rdata0, {16'h0, 16'h3333, 32'h0});
    req0 = 4'h0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
